// File: rtl/ugv_cmd_pkg.sv
// Shared constants, state encoding and byte-lookup helpers for the UGV JSON command formatter.
// Frame shape: {"T":<t>,"L":<l>,"R":<r>}\n
package ugv_cmd_pkg;

    localparam logic [7:0] ASC_LBRACE = 8'h7B;
    localparam logic [7:0] ASC_RBRACE = 8'h7D;
    localparam logic [7:0] ASC_QUOTE  = 8'h22;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_DOT    = 8'h2E;
    localparam logic [7:0] ASC_MINUS  = 8'h2D;
    localparam logic [7:0] ASC_ZERO   = 8'h30;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_T      = 8'h54;
    localparam logic [7:0] ASC_L      = 8'h4C;
    localparam logic [7:0] ASC_R      = 8'h52;

    localparam int SPEED_MAX     = 100;
    localparam int FRAME_MAX_LEN = 28;
    localparam int PREFIX_LEN    = 11;
    localparam int SEP_LEN       = 5;
    localparam int SUFFIX_LEN    = 2;
    localparam int VAL_LEN       = 4;
    // The 11-byte prefix needs a 4-bit byte index.
    localparam int IDX_W         = 4;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        LVAL,
        SEP,
        RVAL,
        SUFFIX
    } fmt_state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASC_ZERO + {4'd0, d};
    endfunction

    function automatic logic [7:0] prefix_byte(input logic [IDX_W-1:0] idx, input logic [7:0] type_char);
        logic [7:0] b;
        case (idx)
            IDX_W'(0):  b = ASC_LBRACE;
            IDX_W'(1):  b = ASC_QUOTE;
            IDX_W'(2):  b = ASC_T;
            IDX_W'(3):  b = ASC_QUOTE;
            IDX_W'(4):  b = ASC_COLON;
            IDX_W'(5):  b = type_char;
            IDX_W'(6):  b = ASC_COMMA;
            IDX_W'(7):  b = ASC_QUOTE;
            IDX_W'(8):  b = ASC_L;
            IDX_W'(9):  b = ASC_QUOTE;
            default:    b = ASC_COLON;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sep_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            IDX_W'(0): b = ASC_COMMA;
            IDX_W'(1): b = ASC_QUOTE;
            IDX_W'(2): b = ASC_R;
            IDX_W'(3): b = ASC_QUOTE;
            default:   b = ASC_COLON;
        endcase
        return b;
    endfunction

    // A leading '-' shifts the digit positions right by one.
    function automatic logic [7:0] value_byte(input logic neg, input logic [7:0] units,
                                              input logic [7:0] tens, input logic [7:0] ones,
                                              input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] pos;
        logic [7:0]       b;
        pos = neg ? idx - IDX_W'(1) : idx;
        if (neg && idx == '0) begin
            b = ASC_MINUS;
        end else begin
            case (pos)
                IDX_W'(0): b = units;
                IDX_W'(1): b = ASC_DOT;
                IDX_W'(2): b = tens;
                default:   b = ones;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/speed_to_ascii.sv
// Clamps a signed hundredths speed to +/-SPEED_MAX and splits its magnitude
// into the three ASCII digits of the "d.dd" field. Purely combinational.
module speed_to_ascii
    import ugv_cmd_pkg::*;
#(
    parameter int SPEED_W = 8
) (
    input  logic signed [SPEED_W-1:0] speed,
    output logic                      neg,
    output logic [7:0]                units,
    output logic [7:0]                tens,
    output logic [7:0]                ones
);
    // Wide enough to hold +/-100 even if the input is narrow.
    localparam int EXT_W = (SPEED_W > 9) ? SPEED_W : 9;
    localparam logic signed [EXT_W-1:0] POS_LIM = EXT_W'(SPEED_MAX);
    localparam logic signed [EXT_W-1:0] NEG_LIM = -EXT_W'(SPEED_MAX);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] clamped;
    logic [6:0]              mag;
    logic [6:0]              rem;

    always_comb begin
        ext = EXT_W'(speed);
        if (ext > POS_LIM) begin
            clamped = POS_LIM;
        end else if (ext < NEG_LIM) begin
            clamped = NEG_LIM;
        end else begin
            clamped = ext;
        end
        neg = clamped[EXT_W-1];
        mag = 7'(neg ? -clamped : clamped);
        // Constant divisors only: these reduce to small compare/subtract logic.
        rem   = mag % 7'd100;
        units = ascii_digit(4'(mag / 7'd100));
        tens  = ascii_digit(4'(rem / 7'd10));
        ones  = ascii_digit(4'(rem % 7'd10));
    end

endmodule

// File: rtl/ugv_json_cmd_formatter.sv
// Turns a latched pair of signed wheel speeds into one JSON motion line and
// streams it a byte at a time over a valid/ready byte interface to uart_tx.
module ugv_json_cmd_formatter
    import ugv_cmd_pkg::*;
#(
    parameter int CMD_TYPE = 1,
    parameter int SPEED_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] cmd_left,
    input  logic signed [SPEED_W-1:0] cmd_right,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      frame_done
);
    localparam logic [7:0] TYPE_CHAR = ASC_ZERO + 8'(CMD_TYPE);

    fmt_state_t                state, state_nx;
    logic [IDX_W-1:0]          idx, idx_nx, field_last;
    logic signed [SPEED_W-1:0] lat_left, lat_right;

    logic       l_neg, r_neg;
    logic [7:0] l_units, l_tens, l_ones;
    logic [7:0] r_units, r_tens, r_ones;

    logic       cmd_take, byte_take, field_end;
    logic [7:0] byte_sel, tx_data_nx;
    logic       tx_valid_nx, cmd_ready_nx, frame_done_nx, load_byte;

    assign cmd_take  = cmd_valid && (state == IDLE);
    assign byte_take = tx_valid && tx_ready;
    assign field_end = byte_take && (idx == field_last);

    speed_to_ascii #(.SPEED_W(SPEED_W)) u_left (
        .speed (lat_left),
        .neg   (l_neg),
        .units (l_units),
        .tens  (l_tens),
        .ones  (l_ones)
    );

    speed_to_ascii #(.SPEED_W(SPEED_W)) u_right (
        .speed (lat_right),
        .neg   (r_neg),
        .units (r_units),
        .tens  (r_tens),
        .ones  (r_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            lat_left   <= '0;
            lat_right  <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            cmd_ready  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nx;
            idx        <= idx_nx;
            if (cmd_take) begin
                lat_left  <= cmd_left;
                lat_right <= cmd_right;
            end
            tx_data    <= tx_data_nx;
            tx_valid   <= tx_valid_nx;
            cmd_ready  <= cmd_ready_nx;
            frame_done <= frame_done_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        field_last = '0;
        state_nx   = state;
        idx_nx     = idx;

        unique case (state)
            PREFIX:  field_last = IDX_W'(PREFIX_LEN - 1);
            LVAL:    field_last = l_neg ? IDX_W'(VAL_LEN) : IDX_W'(VAL_LEN - 1);
            SEP:     field_last = IDX_W'(SEP_LEN - 1);
            RVAL:    field_last = r_neg ? IDX_W'(VAL_LEN) : IDX_W'(VAL_LEN - 1);
            SUFFIX:  field_last = IDX_W'(SUFFIX_LEN - 1);
            default: field_last = '0;
        endcase

        if (state == IDLE) begin
            if (cmd_valid) begin
                state_nx = PREFIX;
                idx_nx   = '0;
            end
        end else if (field_end) begin
            idx_nx = '0;
            unique case (state)
                PREFIX:  state_nx = LVAL;
                LVAL:    state_nx = SEP;
                SEP:     state_nx = RVAL;
                RVAL:    state_nx = SUFFIX;
                default: state_nx = IDLE;
            endcase
        end else if (byte_take) begin
            idx_nx = idx + IDX_W'(1);
        end
    end

    // The next byte is looked up from the next (state, idx) so tx_data is a pure register.
    always_comb begin
        byte_sel = 8'h00;
        unique case (state_nx)
            PREFIX:  byte_sel = prefix_byte(idx_nx, TYPE_CHAR);
            LVAL:    byte_sel = value_byte(l_neg, l_units, l_tens, l_ones, idx_nx);
            SEP:     byte_sel = sep_byte(idx_nx);
            RVAL:    byte_sel = value_byte(r_neg, r_units, r_tens, r_ones, idx_nx);
            SUFFIX:  byte_sel = (idx_nx == '0) ? ASC_RBRACE : ASC_LF;
            default: byte_sel = 8'h00;
        endcase

        // The accept cycle itself stays quiet; the first byte appears one edge later.
        tx_valid_nx   = (state != IDLE) && (state_nx != IDLE);
        load_byte     = tx_valid_nx && (byte_take || !tx_valid);
        tx_data_nx    = load_byte ? byte_sel : tx_data;
        cmd_ready_nx  = (state_nx == IDLE);
        frame_done_nx = field_end && (state == SUFFIX);
    end

endmodule

// File: tb/tb_ugv_json_cmd_formatter.sv
// Scoreboard bench for ugv_json_cmd_formatter: stimulus pushes hand-written
// expected frames, a negedge monitor pops and compares every accepted byte.
module tb_ugv_json_cmd_formatter;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              tx_ready  = 1'b0;
    logic signed [7:0] cmd_left  = '0;
    logic signed [7:0] cmd_right = '0;
    logic              cmd_ready;
    logic              tx_valid;
    logic              frame_done;
    logic [7:0]        tx_data;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         acc_count   = 0;
    int         frame_count = 0;
    int         ready_mode  = 0;
    bit         nl_pending  = 1'b0;

    ugv_json_cmd_formatter #(.CMD_TYPE(1), .SPEED_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_left   (cmd_left),
        .cmd_right  (cmd_right),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Sink: 0 = always ready, 1 = random, 2 = stalled. Updates off-edge.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // Monitor: what is valid&&ready at the negedge is what the next posedge accepts.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            nl_pending = 1'b0;
        end else begin
            if (nl_pending || frame_done) begin
                check("frame_done_pulse", frame_done, nl_pending);
                if (frame_done) begin
                    frame_count++;
                    check("ready_after_frame", cmd_ready, 1);
                end
            end
            nl_pending = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected nothing at %0t", tx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", tx_data, mon_exp);
                end
                acc_count++;
                nl_pending = (tx_data == 8'h0A);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Called and returns at #1 after a posedge; returns just after the accept edge.
    task automatic send_cmd(input logic signed [7:0] l, input logic signed [7:0] r, input string s);
        int t = 0;
        while (!cmd_ready && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("send_wait_ready", cmd_ready, 1);
        push_exp(s);
        cmd_left  = l;
        cmd_right = r;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int t = 0;
        while (acc_count < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("acc_reached", 32'(acc_count >= target), 1);
    endtask

    initial begin
        int         base;
        int         t;
        logic [7:0] held;
        bit         stable;

        // Reset state
        #3;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_done", frame_done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Basic frame with first-byte latency
        ready_mode = 0;
        send_cmd(8'sd50, 8'sd50, "{\"T\":1,\"L\":0.50,\"R\":0.50}\n");
        check("lat_quiet_at_accept", tx_valid, 0);
        check("busy_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("lat_valid", tx_valid, 1);
        check("lat_first_byte", tx_data, 8'h7B);
        wait_drain(200);
        check("frames_after_basic", frame_count, 1);

        // Signed values
        send_cmd(-8'sd25, 8'sd25, "{\"T\":1,\"L\":-0.25,\"R\":0.25}\n");
        wait_drain(200);

        // Clamping under random backpressure plus a long stall mid-LVAL
        ready_mode = 1;
        send_cmd(-8'sd128, 8'sd127, "{\"T\":1,\"L\":-1.00,\"R\":1.00}\n");
        base = acc_count;
        wait_acc(base + 13, 2000);
        ready_mode = 2;
        held   = tx_data;
        stable = 1'b1;
        check("stall_byte", held, 8'h2E);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
            if (i == 500) begin
                cmd_left  = 8'sd5;
                cmd_right = 8'sd5;
                cmd_valid = 1'b1;
                check("busy_ready_low", cmd_ready, 0);
            end
            if (i == 501) begin
                check("busy_ready_still_low", cmd_ready, 0);
                cmd_valid = 1'b0;
            end
        end
        check("stall_stable", stable, 1);
        ready_mode = 1;
        wait_drain(5000);

        send_cmd(8'sd0, -8'sd1, "{\"T\":1,\"L\":0.00,\"R\":-0.01}\n");
        wait_drain(5000);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame after the 10th accepted byte
        send_cmd(8'sd50, -8'sd50, "{\"T\":1,\"L\":0.50,\"R\":-0.50}\n");
        base = acc_count;
        wait_acc(base + 10, 200);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_tx_data", tx_data, 8'h00);
        @(posedge clk);
        #1;
        send_cmd(8'sd100, 8'sd0, "{\"T\":1,\"L\":1.00,\"R\":0.00}\n");
        @(posedge clk);
        #1;
        check("post_rst_first_byte", tx_data, 8'h7B);
        wait_drain(200);

        // Back-to-back with cmd_valid held high
        push_exp("{\"T\":1,\"L\":0.07,\"R\":-1.00}\n");
        cmd_left  = 8'sd7;
        cmd_right = -8'sd100;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first_taken", cmd_ready, 0);
        push_exp("{\"T\":1,\"L\":0.99,\"R\":-0.99}\n");
        cmd_left  = 8'sd99;
        cmd_right = -8'sd99;
        t = 0;
        while (!frame_done && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", frame_done, 1);
        @(posedge clk);
        #1;
        check("b2b_second_taken", cmd_ready, 0);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_second_valid", tx_valid, 1);
        check("b2b_second_first", tx_data, 8'h7B);
        wait_drain(200);

        check("frame_total", frame_count, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
